// File: rtl/counter_pkg.sv
// Shared types and helpers for the manual step counter and its BCD converter.
package counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } bcd_state_e;

  localparam bcd_digit_t BCD_ADD_THRESH = 4'd5;

  // Shift-add-3 correction applied to one digit before each shift.
  function automatic bcd_digit_t add3(input bcd_digit_t d);
    if (d >= BCD_ADD_THRESH) begin
      return d + 4'd3;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter; start restarts it at any state.
module bin2bcd_seq
  import counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH-1:0]        value,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    done
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int ITER_W = $clog2(WIDTH + 1);

  bcd_state_e              state;
  bcd_state_e              state_next;
  logic [WIDTH-1:0]        value_lat;
  logic [WIDTH-1:0]        bin_sh;
  logic [BCD_W-1:0]        acc;
  logic [BCD_W-1:0]        acc_adj;
  logic [ITER_W-1:0]       iter;
  logic [BCD_W+WIDTH-1:0]  shifted;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a start in any state (re)enters LOAD with the new value.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
        else       state_next = IDLE;
      end
      LOAD: begin
        if (start) state_next = LOAD;
        else       state_next = SHIFT;
      end
      SHIFT: begin
        if (start)                              state_next = LOAD;
        else if (iter == ITER_W'(WIDTH - 1))    state_next = DONE;
        else                                    state_next = SHIFT;
      end
      DONE: begin
        if (start) state_next = LOAD;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-digit correction followed by one left shift of the {bcd, binary} pair.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      acc_adj[4*d +: 4] = add3(acc[4*d +: 4]);
    end
    shifted = {acc_adj, bin_sh} << 1'b1;
  end

  // Datapath; bcd is only written in DONE so partial shift data never leaks out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_lat <= WIDTH'(0);
      bin_sh    <= WIDTH'(0);
      acc       <= BCD_W'(0);
      iter      <= ITER_W'(0);
      bcd       <= BCD_W'(0);
      done      <= 1'b1;
    end else if (start) begin
      value_lat <= value;
      done      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          bin_sh <= value_lat;
          acc    <= BCD_W'(0);
          iter   <= ITER_W'(0);
        end
        SHIFT: begin
          {acc, bin_sh} <= shifted;
          iter          <= iter + ITER_W'(1);
        end
        DONE: begin
          bcd  <= acc;
          done <= 1'b1;
        end
        default: begin
          done <= done;
        end
      endcase
    end
  end

endmodule

// File: rtl/manual_step_counter.sv
// Push-button up/down counter with wrap pulse and sequential BCD output.
// Define BTN_DEBOUNCE_EN to insert a per-button debounce filter after the synchronizers.
module manual_step_counter
  import counter_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int MAX_COUNT       = 150,
  parameter int NUM_DIGITS      = 3,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_inc,
  input  logic                    btn_dec,
  input  logic                    enable,
  output logic [WIDTH-1:0]        count,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    bcd_valid,
  output logic                    count_reached
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  logic [1:0]       raw;
  logic [1:0]       step;
  logic [WIDTH-1:0] count_next;
  logic             reached_next;
  logic             conv_start;

  assign raw = {btn_dec, btn_inc};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic sync1;
    logic sync2;
    logic level;
    logic level_d;
    logic pulse;

    // Two-flop synchronizer for the raw button pin.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= raw[g];
        sync2 <= sync1;
      end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0] db_cnt;

    // Filtered level follows sync2 only after it has disagreed for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db_cnt <= DB_W'(0);
        level  <= 1'b0;
      end else if (sync2 != level) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level  <= sync2;
          db_cnt <= DB_W'(0);
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= DB_W'(0);
      end
    end
`else
    assign level = sync2;
`endif

    // Registered rising-edge detect gives a one-clock step pulse.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        level_d <= 1'b0;
        pulse   <= 1'b0;
      end else begin
        level_d <= level;
        pulse   <= level & ~level_d;
      end
    end

    assign step[g] = pulse;
  end

  // Step rules in priority order: disable, simultaneous, inc, dec, hold.
  always_comb begin
    count_next   = count;
    reached_next = 1'b0;
    if (!enable) begin
      count_next = WIDTH'(0);
    end else if (step[0] && step[1]) begin
      count_next = count;
    end else if (step[0]) begin
      if (count == MAX_C) begin
        count_next   = WIDTH'(0);
        reached_next = 1'b1;
      end else begin
        count_next = count + WIDTH'(1);
      end
    end else if (step[1]) begin
      if (count == WIDTH'(0)) begin
        count_next   = MAX_C;
        reached_next = 1'b1;
      end else begin
        count_next = count - WIDTH'(1);
      end
    end else begin
      count_next = count;
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count         <= WIDTH'(0);
      count_reached <= 1'b0;
    end else begin
      count         <= count_next;
      count_reached <= reached_next;
    end
  end

  // Converter is started with the next value so bcd_valid drops with the count change.
  assign conv_start = (count_next != count);

  bin2bcd_seq #(
    .WIDTH      (WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .value (count_next),
    .bcd   (bcd),
    .done  (bcd_valid)
  );

endmodule

// File: tb/tb_manual_step_counter.sv
// Randomized self-checking bench for manual_step_counter against a decimal reference model.
module tb_manual_step_counter;

  localparam int WIDTH      = 8;
  localparam int MAX_COUNT  = 150;
  localparam int NUM_DIGITS = 3;
  localparam int DB         = 8;
`ifdef BTN_DEBOUNCE_EN
  localparam int EXTRA = DB;
`else
  localparam int EXTRA = 0;
`endif
  localparam int HOLD = EXTRA + 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_inc;
  logic        btn_dec;
  logic        enable;
  logic [7:0]  count;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        count_reached;

  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  int          bcd_changes = 0;
  logic [11:0] bcd_prev;
  int          model = 0;

  manual_step_counter #(
    .WIDTH           (WIDTH),
    .MAX_COUNT       (MAX_COUNT),
    .NUM_DIGITS      (NUM_DIGITS),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_inc       (btn_inc),
    .btn_dec       (btn_dec),
    .enable        (enable),
    .count         (count),
    .bcd           (bcd),
    .bcd_valid     (bcd_valid),
    .count_reached (count_reached)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    return {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Continuous monitor: wrap pulses, bcd consistency, and no bcd change without valid.
  always @(negedge clk) begin
    if (count_reached === 1'b1) pulses <= pulses + 1;
    if (bcd_valid === 1'b1) check_val("bcd_tracks_count", bcd, to_bcd(int'(count)));
    if (bcd !== bcd_prev) begin
      bcd_changes <= bcd_changes + 1;
      check_val("bcd_change_only_when_valid", bcd_valid, 1);
    end
    bcd_prev <= bcd;
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (bcd_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("bcd_valid_settles", bcd_valid, 1);
  endtask

  task automatic press(input logic inc, input logic dec);
    @(negedge clk);
    btn_inc = inc;
    btn_dec = dec;
    ticks(HOLD);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    ticks(HOLD);
  endtask

  // kind: 0 = inc, 1 = dec, 2 = both at once.
  task automatic step_op(input int kind, input string tag);
    int p0;
    int exp_p;
    p0 = pulses;
    exp_p = 0;
    if (kind == 0) begin
      if (model == MAX_COUNT) begin model = 0; exp_p = 1; end
      else model = model + 1;
    end else if (kind == 1) begin
      if (model == 0) begin model = MAX_COUNT; exp_p = 1; end
      else model = model - 1;
    end
    press(kind != 1, kind != 0);
    wait_valid();
    ticks(1);
    check_val({tag, "_count"}, count, model);
    check_val({tag, "_pulse"}, pulses - p0, exp_p);
    check_val({tag, "_bcd"}, bcd, to_bcd(model));
  endtask

  task automatic clear_op(input string tag);
    int p0;
    p0 = pulses;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    model = 0;
    wait_valid();
    ticks(1);
    check_val({tag, "_count"}, count, 0);
    check_val({tag, "_pulse"}, pulses - p0, 0);
    check_val({tag, "_bcd"}, bcd, 12'h000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    int p0;
    int bc0;
    reset   = 1'b1;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    enable  = 1'b1;
    ticks(3);
    check_val("rst_count", count, 0);
    check_val("rst_bcd", bcd, 12'h000);
    check_val("rst_bcd_valid", bcd_valid, 1);
    check_val("rst_reached", count_reached, 0);
    reset = 1'b0;
    ticks(2);

    // Full sweep 0..150 then wrap to 0.
    for (int i = 0; i < MAX_COUNT; i++) step_op(0, "sweep");
    check_val("sweep_bcd_at_max", bcd, 12'h150);
    step_op(0, "sweep_wrap");

    // Decrement from 0 with exact step and conversion latency.
    p0 = pulses;
    @(negedge clk);
    btn_dec = 1'b1;
    n = 0;
    while (count === 8'd0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("dec_step_latency", n, 4 + EXTRA);
    check_val("dec_valid_drops", bcd_valid, 0);
    m = 0;
    while (bcd_valid !== 1'b1 && m < 60) begin
      @(negedge clk);
      m++;
    end
    check_val("bcd_latency", m, WIDTH + 2);
    btn_dec = 1'b0;
    ticks(HOLD);
    model = MAX_COUNT;
    check_val("dec_wrap_count", count, MAX_COUNT);
    check_val("dec_wrap_pulse", pulses - p0, 1);
    check_val("dec_wrap_bcd", bcd, 12'h150);

    // Up to 42, then simultaneous presses.
    step_op(0, "to_zero");
    for (int i = 0; i < 42; i++) step_op(0, "to42");
    bc0 = bcd_changes;
    step_op(2, "both");
    check_val("both_no_bcd_change", bcd_changes - bc0, 0);

    // Up to 99, then a one-clock disable.
    for (int i = 0; i < 57; i++) step_op(0, "to99");
    check_val("at99_bcd", bcd, 12'h099);
    clear_op("enable_pulse");

    // Presses while disabled are ignored.
    step_op(0, "pre_disable");
    @(negedge clk);
    enable = 1'b0;
    model = 0;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    @(negedge clk);
    enable = 1'b1;
    ticks(HOLD + 20);
    check_val("disabled_count", count, 0);
    check_val("disabled_bcd", bcd, 12'h000);

`ifndef BTN_DEBOUNCE_EN
    // Two inc steps two clocks apart: second restarts the conversion.
    bc0 = bcd_changes;
    @(negedge clk); btn_inc = 1'b1;
    @(negedge clk); btn_inc = 1'b0;
    @(negedge clk); btn_inc = 1'b1;
    @(negedge clk); btn_inc = 1'b0;
    ticks(4);
    wait_valid();
    ticks(1);
    model = 2;
    check_val("pair_count", count, 2);
    check_val("pair_bcd", bcd, 12'h002);
    check_val("pair_single_bcd_update", bcd_changes - bc0, 1);
`else
    // Short glitch is filtered, a long hold gives one step.
    p0 = model;
    @(negedge clk); btn_inc = 1'b1;
    ticks(3);
    btn_inc = 1'b0;
    ticks(DB + 12);
    check_val("glitch_no_step", count, p0);
    @(negedge clk); btn_inc = 1'b1;
    ticks(10);
    btn_inc = 1'b0;
    ticks(DB + 8);
    wait_valid();
    model = model + 1;
    check_val("hold_one_step", count, model);
`endif

    // Randomized mix of operations.
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 3);
      if (k == 3) clear_op("rand_clear");
      else step_op(k, "rand");
      ticks($urandom_range(0, 3));
    end

    // Async reset while a button is held and a conversion is in flight.
    if (model == 0) step_op(0, "pre_reset");
    @(negedge clk);
    btn_inc = 1'b1;
    p0 = int'(count);
    n = 0;
    while (int'(count) == p0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    ticks(2);
    #2 reset = 1'b1;
    #1;
    check_val("midrst_count", count, 0);
    check_val("midrst_bcd", bcd, 12'h000);
    check_val("midrst_bcd_valid", bcd_valid, 1);
    check_val("midrst_reached", count_reached, 0);
    btn_inc = 1'b0;
    ticks(2);
    reset = 1'b0;
    model = 0;
    ticks(HOLD + 20);
    check_val("post_rst_count", count, 0);
    check_val("post_rst_bcd_valid", bcd_valid, 1);
    step_op(1, "post_rst_dec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
